// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side pointer, empty/almost-empty, occupancy and underflow
module fifo_rd_ctrl #(
    parameter int ASIZE    = 2,
    parameter int AE_LEVEL = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rcount,
    output logic             runderflow
);

    localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AE_LEVEL);

    logic [ASIZE:0] r_rbin;
    logic [ASIZE:0] r_rptr;
    logic           r_rempty;
    logic           r_raempty;
    logic [ASIZE:0] r_rcount;
    logic           r_runderflow;

    logic           w_rd_ok;
    logic [ASIZE:0] w_rbin_next;
    logic [ASIZE:0] w_rgray_next;
    logic [ASIZE:0] w_wbin;
    logic [ASIZE:0] w_rcount_next;

    // Read is accepted only against the registered empty flag, so rinc never
    // reaches rempty combinationally.
    always_comb begin
        w_rd_ok       = rinc & ~r_rempty;
        w_rbin_next   = r_rbin + {{ASIZE{1'b0}}, w_rd_ok};
        w_rgray_next  = (w_rbin_next >> 1) ^ w_rbin_next;
        w_wbin        = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            w_wbin[i] = ^(rq2_wptr >> i);
        end
        w_rcount_next = w_wbin - w_rbin_next;
    end

    always_ff @(posedge rclk) begin
        if (!rrst) begin
            r_rbin       <= '0;
            r_rptr       <= '0;
            r_rempty     <= 1'b1;
            r_raempty    <= 1'b1;
            r_rcount     <= '0;
            r_runderflow <= 1'b0;
        end else begin
            r_rbin       <= w_rbin_next;
            r_rptr       <= w_rgray_next;
            r_rempty     <= (w_rgray_next == rq2_wptr);
            r_raempty    <= (w_rcount_next <= AE_LVL);
            r_rcount     <= w_rcount_next;
            r_runderflow <= rinc & r_rempty;
        end
    end

    assign raddr      = r_rbin[ASIZE-1:0];
    assign rptr       = r_rptr;
    assign rempty     = r_rempty;
    assign raempty    = r_raempty;
    assign rcount     = r_rcount;
    assign runderflow = r_runderflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

    localparam int ASIZE = 2;
    localparam int AE    = 1;
    localparam int DEPTH = 4;
    localparam int LAPS  = 8;

    logic       rclk = 1'b0;
    logic       rrst = 1'b0;
    logic       rinc = 1'b0;
    logic [2:0] rq2_wptr = 3'b000;
    logic [1:0] raddr;
    logic [2:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [2:0] rcount;
    logic       runderflow;

    int total = 0;
    int bad   = 0;

    fifo_rd_ctrl #(.ASIZE(ASIZE), .AE_LEVEL(AE)) dut (
        .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
        .rcount(rcount), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    function automatic int b2g(int b);
        return (b ^ (b >> 1)) & (LAPS - 1);
    endfunction

    function automatic int g2b(logic [2:0] g);
        for (int b = 0; b < LAPS; b++) if (b2g(b) == int'(g)) return b;
        return 0;
    endfunction

    // Reference model: read count modulo 2*DEPTH, flags from occupancy.
    int m_rd = 0;
    int m_count = 0;
    bit m_empty = 1;
    bit m_aempty = 1;
    bit m_under = 0;
    bit m_valid = 0;

    always @(posedge rclk) begin
        int occ;
        if (!rrst) begin
            m_rd = 0; m_count = 0; m_empty = 1; m_aempty = 1; m_under = 0;
        end else begin
            m_under = rinc && m_empty;
            if (rinc && !m_empty) m_rd = (m_rd + 1) % LAPS;
            occ = (g2b(rq2_wptr) - m_rd + LAPS) % LAPS;
            m_count  = occ;
            m_empty  = (occ == 0);
            m_aempty = (occ <= AE);
        end
        m_valid = 1;
    end

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rclk) begin
        if (m_valid) begin
            check("m_rptr",    int'(rptr),       b2g(m_rd));
            check("m_raddr",   int'(raddr),      m_rd % DEPTH);
            check("m_rempty",  int'(rempty),     int'(m_empty));
            check("m_raempty", int'(raempty),    int'(m_aempty));
            check("m_rcount",  int'(rcount),     m_count);
            check("m_under",   int'(runderflow), int'(m_under));
        end
    end

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    int exp_addr[4] = '{1, 2, 3, 0};
    int exp_ptr[4]  = '{1, 3, 2, 6};
    int exp_cnt[4]  = '{3, 2, 1, 0};
    int tb_w;

    initial begin
        // 1: reset dominance
        rrst = 0; rinc = 1; rq2_wptr = 3'b011;
        step(); step();
        check("rst_rptr", rptr, 0);
        check("rst_raddr", raddr, 0);
        check("rst_rempty", rempty, 1);
        check("rst_raempty", raempty, 1);
        check("rst_rcount", rcount, 0);
        check("rst_under", runderflow, 0);
        rrst = 1; rinc = 0;
        step();
        check("post_rst_rempty", rempty, 0);
        check("post_rst_rcount", rcount, 2);
        check("post_rst_raempty", raempty, 0);

        // 2: drain full FIFO
        rrst = 0; step();
        rrst = 1; rq2_wptr = 3'b110; step();
        check("full_rcount", rcount, 4);
        rinc = 1;
        for (int i = 0; i < 4; i++) begin
            check("drain_raddr_pre", raddr, (i + 4 - 1 + 1) % 4);
            step();
            check("drain_raddr", raddr, exp_addr[i]);
            check("drain_rptr", rptr, exp_ptr[i]);
            check("drain_rcount", rcount, exp_cnt[i]);
            check("drain_raempty", raempty, exp_cnt[i] <= 1);
            check("drain_rempty", rempty, i == 3);
        end

        // 3: underflow while empty
        for (int i = 0; i < 3; i++) begin
            step();
            check("uf_pulse", runderflow, 1);
            check("uf_rptr", rptr, 3'b110);
            check("uf_raddr", raddr, 0);
            check("uf_rempty", rempty, 1);
        end
        rinc = 0; step();
        check("uf_clear", runderflow, 0);

        // 4: wrap-around (advance to rbin=7 first)
        rq2_wptr = 3'b000; step();
        rinc = 1; step(); step(); step();
        rinc = 0; rq2_wptr = 3'b001; step();
        check("wrap_start_rptr", rptr, 3'b100);
        check("wrap_start_rcount", rcount, 2);
        rinc = 1; step();
        check("wrap_rptr", rptr, 3'b000);
        check("wrap_raddr", raddr, 0);
        check("wrap_rcount", rcount, 1);
        step();
        check("wrap_rempty", rempty, 1);

        // 5: last read coincides with a write
        rinc = 0; rq2_wptr = 3'b011; step();
        check("sim_pre_rcount", rcount, 1);
        rinc = 1; rq2_wptr = 3'b010; step();
        check("sim_rempty", rempty, 0);
        check("sim_rcount", rcount, 1);
        check("sim_under", runderflow, 0);

        // 6: reset mid-operation
        rinc = 0; rq2_wptr = 3'b110; step();
        check("mid_pre_rptr", rptr, 3'b011);
        check("mid_pre_rcount", rcount, 2);
        rrst = 0; step();
        check("mid_rptr", rptr, 0);
        check("mid_rempty", rempty, 1);
        check("mid_raempty", raempty, 1);
        check("mid_rcount", rcount, 0);
        rrst = 1; rq2_wptr = 3'b000; tb_w = 0; step();

        // Randomized traffic with legal write-pointer advances
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rrst = 0; tb_w = 0;
            end else begin
                rrst = 1;
                if (((tb_w - m_rd + LAPS) % LAPS) < DEPTH && $urandom_range(0, 2) != 0)
                    tb_w = (tb_w + 1) % LAPS;
            end
            rq2_wptr = 3'(b2g(tb_w));
            rinc = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
